// File: rtl/video_pixel_unpacker.sv
// Unpacks packed framebuffer words into one 8:8:8:PAD pixel per beat; modes latched on start-of-frame words.
// Latency: pixel 0 of a word is valid the cycle after the word is accepted; one pixel per cycle sustained.
// Backpressure: one-word buffer; input ready only when the buffer is empty or its last pixel leaves this cycle.
module video_pixel_unpacker #(
    parameter int          IN_W      = 32,
    parameter int          BYTE_SWAP = 0,
    parameter logic [7:0]  PAD       = 8'h00,
    parameter int          DROP_W    = 16
) (
    input  logic              vid_aclk,
    input  logic              vid_areset,
    input  logic [IN_W-1:0]   m_axis_vid_tdata,
    input  logic              m_axis_vid_tvalid,
    output logic              m_axis_vid_tready,
    input  logic              m_axis_vid_tuser,
    input  logic              m_axis_vid_tlast,
    output logic [31:0]       s_axis_vid_tdata,
    output logic              s_axis_vid_tvalid,
    input  logic              s_axis_vid_tready,
    output logic              s_axis_vid_tuser,
    output logic              s_axis_vid_tlast,
    input  logic [1:0]        mode,
    output logic [DROP_W-1:0] drop_count
);

    localparam int IDX_W = $clog2(IN_W / 8);

    typedef enum logic {HUNT, RUN} state_t;

    state_t            state_q, state_d;
    logic [IN_W-1:0]   w_q;
    logic [IDX_W-1:0]  idx_q;
    logic [IDX_W-1:0]  last_idx;
    logic              full_q;
    logic              sof_q;
    logic              eol_q;
    logic [1:0]        mode_q;
    logic [DROP_W-1:0] drop_q;
    logic              pix_last;
    logic              in_acc;
    logic              out_acc;
    logic [31:0]       lane32;
    logic [15:0]       lane16;
    logic [7:0]        lane8;
    logic [15:0]       x;

    // Index of the final pixel in the buffered word for the latched mode
    always_comb begin
        unique case (mode_q)
            2'd0:    last_idx = IDX_W'(IN_W / 32 - 1);
            2'd1,
            2'd2:    last_idx = IDX_W'(IN_W / 16 - 1);
            default: last_idx = IDX_W'(IN_W / 8 - 1);
        endcase
    end

    assign pix_last = (idx_q == last_idx);
    assign in_acc   = m_axis_vid_tvalid && m_axis_vid_tready;
    assign out_acc  = full_q && s_axis_vid_tready;

    // FSM state register
    always_ff @(posedge vid_aclk or posedge vid_areset) begin
        if (vid_areset) state_q <= HUNT;
        else            state_q <= state_d;
    end

    // FSM next state: leave HUNT on the first start-of-frame word; RUN is sticky until reset
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            HUNT:    if (in_acc && m_axis_vid_tuser) state_d = RUN;
            default: state_d = RUN;
        endcase
    end

    // FSM outputs: handshakes and frame markers
    always_comb begin
        m_axis_vid_tready = (state_q == HUNT) || !full_q || (s_axis_vid_tready && pix_last);
        s_axis_vid_tvalid = full_q;
        s_axis_vid_tuser  = full_q && sof_q && (idx_q == '0);
        s_axis_vid_tlast  = full_q && eol_q && pix_last;
        drop_count        = drop_q;
    end

    // Word buffer, pixel index, latched mode and drop counter; a load overrides the free of the last pixel
    always_ff @(posedge vid_aclk or posedge vid_areset) begin
        if (vid_areset) begin
            w_q    <= '0;
            idx_q  <= '0;
            full_q <= 1'b0;
            sof_q  <= 1'b0;
            eol_q  <= 1'b0;
            mode_q <= 2'd0;
            drop_q <= '0;
        end else begin
            if (out_acc) begin
                if (pix_last) begin
                    full_q <= 1'b0;
                    idx_q  <= '0;
                end else begin
                    idx_q  <= idx_q + IDX_W'(1);
                end
            end
            if (in_acc && (state_q == RUN || m_axis_vid_tuser)) begin
                w_q    <= m_axis_vid_tdata;
                full_q <= 1'b1;
                idx_q  <= '0;
                sof_q  <= m_axis_vid_tuser;
                eol_q  <= m_axis_vid_tlast;
                if (m_axis_vid_tuser) mode_q <= mode;
            end else if (in_acc && drop_q != {DROP_W{1'b1}}) begin
                drop_q <= drop_q + DROP_W'(1);
            end
        end
    end

    // Lane select for the current pixel and per-mode expansion to 8:8:8 plus pad
    always_comb begin
        lane32 = 32'(w_q >> {idx_q, 5'd0});
        lane16 = 16'(w_q >> {idx_q, 4'd0});
        lane8  = 8'(w_q >> {idx_q, 3'd0});
        x      = (BYTE_SWAP != 0) ? {lane16[7:0], lane16[15:8]} : lane16;
        unique case (mode_q)
            2'd0: s_axis_vid_tdata = lane32;
            2'd1: s_axis_vid_tdata = {x[4:0], x[4:2], x[10:5], x[10:9], x[15:11], x[15:13], PAD};
            2'd2: s_axis_vid_tdata = {x[4:0], x[4:2], x[9:5], x[9:7], x[14:10], x[14:12], PAD};
            default: s_axis_vid_tdata = {lane8, lane8, lane8, PAD};
        endcase
    end

endmodule

// File: tb/tb_video_pixel_unpacker.sv
// Bench for the pixel unpacker: directed vectors plus randomized traffic against a queue-based pixel model.
// Latency: model predicts each beat at word acceptance; compared on output handshake.
// Backpressure: randomized output ready; input ready predicted from pending pixel count.
module tb_video_pixel_unpacker;

    localparam int         IN_W   = 64;
    localparam int         BSWAP  = 1;
    localparam logic [7:0] PADV   = 8'hAA;
    localparam int         DROP_W = 3;

    logic              clk = 0;
    logic              rst = 1;
    logic [IN_W-1:0]   m_tdata = '0;
    logic              m_tvalid = 0;
    logic              m_tready;
    logic              m_tuser = 0;
    logic              m_tlast = 0;
    logic [31:0]       s_tdata;
    logic              s_tvalid;
    logic              s_tready = 1;
    logic              s_tuser;
    logic              s_tlast;
    logic [1:0]        mode = 0;
    logic [DROP_W-1:0] drop_count;

    video_pixel_unpacker #(.IN_W(IN_W), .BYTE_SWAP(BSWAP), .PAD(PADV), .DROP_W(DROP_W)) dut (
        .vid_aclk(clk), .vid_areset(rst),
        .m_axis_vid_tdata(m_tdata), .m_axis_vid_tvalid(m_tvalid), .m_axis_vid_tready(m_tready),
        .m_axis_vid_tuser(m_tuser), .m_axis_vid_tlast(m_tlast),
        .s_axis_vid_tdata(s_tdata), .s_axis_vid_tvalid(s_tvalid), .s_axis_vid_tready(s_tready),
        .s_axis_vid_tuser(s_tuser), .s_axis_vid_tlast(s_tlast),
        .mode(mode), .drop_count(drop_count)
    );

    always #5 clk = ~clk;

    int n_chk  = 0;
    int n_fail = 0;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // ---------------- reference model ----------------
    typedef struct {
        logic [31:0] dat;
        logic        u;
        logic        l;
    } beat_t;

    beat_t       exp_q[$];
    logic [31:0] cap[$];
    bit          hunting = 1;
    int          m_drop  = 0;
    logic [1:0]  m_mode  = 0;

    function automatic int exp5(int v); return (v << 3) | (v >> 2); endfunction
    function automatic int exp6(int v); return (v << 2) | (v >> 4); endfunction

    function automatic logic [31:0] pixel(logic [63:0] w, logic [1:0] md, int p);
        int xv, r, g, b, y;
        case (md)
            2'd0: return w[p*32 +: 32];
            2'd3: begin
                y = int'(w[p*8 +: 8]);
                return 32'((y * 32'h010101) << 8) | 32'(PADV);
            end
            default: begin
                xv = int'(w[p*16 +: 16]);
                if (BSWAP != 0) xv = ((xv & 255) << 8) | (xv >> 8);
                r = exp5(xv & 31);
                if (md == 2'd1) begin
                    g = exp6((xv >> 5) & 63);
                    b = exp5((xv >> 11) & 31);
                end else begin
                    g = exp5((xv >> 5) & 31);
                    b = exp5((xv >> 10) & 31);
                end
                return 32'((r << 24) | (g << 16) | (b << 8) | int'(PADV));
            end
        endcase
    endfunction

    task automatic model_accept(input logic [63:0] w, input logic u, input logic l, input logic [1:0] md);
        int ppw;
        beat_t bt;
        if (hunting && !u) begin
            if (m_drop < (1 << DROP_W) - 1) m_drop++;
        end else begin
            hunting = 0;
            if (u) m_mode = md;
            ppw = (m_mode == 0) ? IN_W / 32 : (m_mode == 3) ? IN_W / 8 : IN_W / 16;
            for (int p = 0; p < ppw; p++) begin
                bt.dat = pixel(w, m_mode, p);
                bt.u   = u && (p == 0);
                bt.l   = l && (p == ppw - 1);
                exp_q.push_back(bt);
            end
        end
    endtask

    // Scoreboard: evaluated mid-cycle, predicting what the next rising edge transfers
    beat_t mon_b;
    always @(negedge clk) begin
        if (rst) begin
            exp_q.delete();
            hunting = 1;
            m_drop  = 0;
            m_mode  = 0;
        end else begin
            chk("s_tvalid", s_tvalid, exp_q.size() != 0);
            chk("m_tready", m_tready, exp_q.size() == 0 || (exp_q.size() == 1 && s_tready));
            chk("drop_count", drop_count, m_drop);
            if (s_tvalid && s_tready) begin
                cap.push_back(s_tdata);
                if (exp_q.size() == 0) begin
                    chk("unexpected_beat", 1, 0);
                end else begin
                    mon_b = exp_q.pop_front();
                    chk("tdata", s_tdata, mon_b.dat);
                    chk("tuser", s_tuser, mon_b.u);
                    chk("tlast", s_tlast, mon_b.l);
                end
            end
            if (m_tvalid && m_tready) model_accept(m_tdata, m_tuser, m_tlast, mode);
        end
    end

    // ---------------- stimulus helpers ----------------
    task automatic send(input logic [63:0] d, input logic u, input logic l, input logic [1:0] md);
        bit ok = 0;
        m_tdata = d; m_tuser = u; m_tlast = l; mode = md; m_tvalid = 1;
        for (int i = 0; i < 500 && !ok; i++) begin
            @(negedge clk);
            if (m_tready) ok = 1;
            @(posedge clk); #1;
        end
        if (!ok) chk("send_timeout", 0, 1);
    endtask

    task automatic idle();
        m_tvalid = 0; m_tuser = 0; m_tlast = 0;
    endtask

    task automatic drain();
        int i = 0;
        s_tready = 1;
        while (i < 300 && (s_tvalid || exp_q.size() != 0)) begin
            @(posedge clk); #1;
            i++;
        end
        if (s_tvalid) chk("drain_timeout", 0, 1);
    endtask

    logic [31:0] m3_tab[8] = '{32'h101010AA, 32'h202020AA, 32'h404040AA, 32'h808080AA,
                               32'h000000AA, 32'h000000AA, 32'h000000AA, 32'h000000AA};
    logic [31:0] m1_tab[4] = '{32'hFF0000AA, 32'h0000FFAA, 32'h00FF00AA, 32'h000000AA};
    bit rdone = 0;

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        // reset values
        repeat (3) @(posedge clk);
        #1;
        chk("rst_m_tready", m_tready, 1);
        chk("rst_s_tvalid", s_tvalid, 0);
        chk("rst_s_tdata", s_tdata, 0);
        chk("rst_s_tuser", s_tuser, 0);
        chk("rst_s_tlast", s_tlast, 0);
        chk("rst_drop", drop_count, 0);
        rst = 0;

        // hunting: two non-SOF words dropped, third starts output (mode 1, byte swapped lanes)
        send(64'h1111_2222_3333_4444, 0, 0, 1);
        send(64'h5555_6666_7777_8888, 0, 1, 1);
        idle();
        @(posedge clk); #1;
        chk("hunt_drop2", drop_count, 2);
        chk("hunt_no_out", s_tvalid, 0);
        cap.delete();
        send(64'h0000_E007_00F8_1F00, 1, 1, 1);
        idle();
        chk("first_pix_valid", s_tvalid, 1);
        drain();
        chk("m1_count", cap.size(), 4);
        for (int i = 0; i < 4 && i < cap.size(); i++) chk("m1_pix", cap[i], m1_tab[i]);

        // grey mode expansion with pad
        cap.delete();
        send(64'h0000_0000_8040_2010, 1, 1, 3);
        idle();
        drain();
        chk("m3_count", cap.size(), 8);
        for (int i = 0; i < 8 && i < cap.size(); i++) chk("m3_pix", cap[i], m3_tab[i]);

        // mode 0 stream of 8 words with a 3-cycle output stall; later mode changes ignored
        cap.delete();
        s_tready = 1;
        fork
            begin
                for (int k = 0; k < 8; k++)
                    send({32'h1000_0000 + 32'(2*k+1), 32'h1000_0000 + 32'(2*k)},
                         k == 0, k == 7, (k == 0) ? 2'd0 : 2'd3);
                idle();
            end
            begin
                repeat (3) @(posedge clk);
                #1 s_tready = 0;
                repeat (3) @(posedge clk);
                #1 s_tready = 1;
            end
        join
        drain();
        chk("m0_count", cap.size(), 16);
        for (int i = 0; i < 16 && i < cap.size(); i++) chk("m0_pix", cap[i], 32'h1000_0000 + 32'(i));

        // reset while the second pixel of a mode-1 word is pending
        s_tready = 0;
        send(64'h1234_5678_9ABC_DEF0, 1, 0, 1);
        idle();
        s_tready = 1;
        @(posedge clk); #1;
        s_tready = 0;
        chk("pend_valid", s_tvalid, 1);
        #2 rst = 1;
        #1;
        chk("arst_s_tvalid", s_tvalid, 0);
        chk("arst_s_tdata", s_tdata, 0);
        chk("arst_m_tready", m_tready, 1);
        chk("arst_drop", drop_count, 0);
        @(posedge clk); #2 rst = 0;
        s_tready = 1;
        @(posedge clk); #1;
        send(64'hFFFF_FFFF_FFFF_FFFF, 0, 0, 0);
        idle();
        @(posedge clk); #1;
        chk("post_rst_hunt_drop", drop_count, 1);
        chk("post_rst_no_out", s_tvalid, 0);

        // saturation of the narrow drop counter
        for (int k = 0; k < 8; k++) send(64'(k), 0, 0, 2);
        idle();
        @(posedge clk); #1;
        chk("drop_sat", drop_count, 7);

        // randomized traffic with random output backpressure
        fork
            begin
                while (!rdone) begin
                    @(posedge clk); #1;
                    s_tready = ($urandom_range(0, 3) != 0);
                end
            end
            begin
                send({$urandom, $urandom}, 1, 0, 2'($urandom_range(0, 3)));
                for (int k = 0; k < 400; k++) begin
                    if ($urandom_range(0, 3) == 0) begin
                        idle();
                        repeat ($urandom_range(1, 2)) @(posedge clk);
                        #1;
                    end
                    send({$urandom, $urandom}, $urandom_range(0, 5) == 0,
                         1'($urandom_range(0, 1)), 2'($urandom_range(0, 3)));
                end
                idle();
                rdone = 1;
            end
        join
        drain();
        chk("final_empty", exp_q.size(), 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule

// File: doc/video_pixel_unpacker.md
Name: video_pixel_unpacker

Overview:
- AXI4-Stream video pixel-format unpacker between the framebuffer reader (packed words) and the video output pipeline (one 32-bit RGBX pixel per beat).
- Splits each input word into 1..IN_W/8 pixels according to a per-frame format mode and expands each to 8:8:8 plus pad byte.
- Adds over the previous converter: full ready/valid backpressure, frame sync hunting, four modes, parametrised input width, optional 16-bit byte swap.

Parameters:
- IN_W, 32, input word width; 32 or 64 only.
- BYTE_SWAP, 0, 1 = swap the two bytes of each 16-bit lane before decode (modes 1, 2 only).
- PAD, 8'h00, constant placed in s_axis_vid_tdata[7:0].
- DROP_W, 16, width of the saturating drop counter.

Ports:
- vid_aclk  in  1  clock for both streams.
- vid_areset  in  1  asynchronous, active-high reset.
- m_axis_vid_tdata  in  IN_W  packed input word.
- m_axis_vid_tvalid  in  1  input valid.
- m_axis_vid_tready  out  1  input ready.
- m_axis_vid_tuser  in  1  start of frame (first word of frame).
- m_axis_vid_tlast  in  1  end of line (last word of line).
- s_axis_vid_tdata  out  32  {R[7:0],G[7:0],B[7:0],PAD}.
- s_axis_vid_tvalid  out  1  output valid.
- s_axis_vid_tready  in  1  output ready.
- s_axis_vid_tuser  out  1  start of frame, first pixel only.
- s_axis_vid_tlast  out  1  end of line, last pixel of the tlast word only.
- mode  in  2  0=XRGB8888, 1=RGB565, 2=RGB555, 3=8-bit grey; sampled only on tuser words.
- drop_count  out  DROP_W  words discarded while hunting; saturates at all-ones.

Behaviour:
- Reset: all outputs 0 except m_axis_vid_tready=1. Buffer empty, state HUNT, latched mode=0, drop_count=0. Reset mid-frame discards the buffered word and pending pixels; nothing partial is emitted afterwards.
- State HUNT:
  - tready=1; every accepted word with tuser=0 is dropped, drop_count++ (saturating).
  - A word with tuser=1 is loaded into the buffer, mode is latched, state goes to RUN.
- State RUN:
  - One-word buffer W with pixel index idx (0..PPW-1), full flag F, latched sof/eol flags.
  - PPW: mode0 = IN_W/32; modes 1, 2 = IN_W/16; mode3 = IN_W/8.
  - s_axis_vid_tvalid = F. s_axis_vid_tdata is combinational from W, idx and the latched mode; stable while tvalid && !tready.
  - Output beat completes when tvalid && tready: idx++, or, at idx=PPW-1, buffer frees.
  - m_axis_vid_tready = !F || (s_axis_vid_tready && idx==PPW-1). Zero-bubble: last pixel and next-word load in the same cycle.
  - Latency: word accepted at edge N gives pixel 0 valid after edge N.
  - Sustained throughput: one pixel per cycle.
- Mode latch: mode is latched only when a tuser=1 word is accepted. A tuser word seen in RUN re-latches mode and does not re-enter HUNT. mode changes mid-frame are ignored.
- Pixel order: pixel 0 comes from the least-significant lane.
- Mode 0: lane[31:0] passed unchanged.
- Mode 1 (16-bit lane x): R5=x[4:0], G6=x[10:5], B5=x[15:11].
- Mode 2 (16-bit lane x): R5=x[4:0], G5=x[9:5], B5=x[14:10]; x[15] ignored.
- Expansion by MSB replication:
  - 5→8: {v,v[4:2]}.
  - 6→8: {v,v[5:4]}.
- Mode 3: lane byte g → {g,g,g,PAD}.
- s_axis_vid_tuser = sof && idx==0.
- s_axis_vid_tlast = eol && idx==PPW-1.

Test Plan:
- IN_W=32, mode=1, word 0xF800001F with tuser=1, tlast=1 → beats 0xFF000000 (tuser=1, tlast=0), then 0x0000FF00 (tuser=0, tlast=1). Lane 0x07E0 → 0x00FF0000.
- BYTE_SWAP=1, mode=1, word 0x00001F00 → pixel 0 = 0xFF000000, pixel 1 = 0x00000000.
- mode=3, PAD=8'hAA, word 0x80402010 → 0x101010AA, 0x202020AA, 0x404040AA, 0x808080AA in order, then m_axis_vid_tready=1 on the last beat.
- After reset, two words with tuser=0 then one with tuser=1 → drop_count=2, no output for the first two, output starts from the third.
- mode=0 streaming 8 words with s_axis_vid_tready held 0 for cycles 3-5 → tdata held stable, m_axis_vid_tready=0 during the stall, all 8 words emitted in order, one per cycle otherwise.
- Assert vid_areset while the second pixel of a mode-1 word is pending → outputs clear immediately; after release, state is HUNT and drop_count=0.
